// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundles the ID-stage issue request, the WB retire notification and the
//   scoreboard responses into one interface. The decoder/pipeline side uses the
//   master modport. The scoreboard uses the slave modport.
//   Issue side : issue_valid, issue_reg_wr, issue_dest_idx, issue_lat_class,
//                src_used, src_idx (operand i at [i*IDX_W +: IDX_W]), flush
//   Retire side: wb_valid, wb_dest_idx
//   Responses  : stall, fwd_sel (2 bits per operand), pend_vec, outstanding, sb_err
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 2
);
  logic                          issue_valid;
  logic                          issue_reg_wr;
  logic [IDX_W-1:0]              issue_dest_idx;
  logic [1:0]                    issue_lat_class;
  logic [NUM_SRC-1:0]            src_used;
  logic [NUM_SRC*IDX_W-1:0]      src_idx;
  logic                          flush;
  logic                          wb_valid;
  logic [IDX_W-1:0]              wb_dest_idx;
  logic                          stall;
  logic [2*NUM_SRC-1:0]          fwd_sel;
  logic [NUM_REGS-1:0]           pend_vec;
  logic [$clog2(NUM_REGS+1)-1:0] outstanding;
  logic                          sb_err;

  modport master (
    output issue_valid, issue_reg_wr, issue_dest_idx, issue_lat_class,
    output src_used, src_idx, flush, wb_valid, wb_dest_idx,
    input  stall, fwd_sel, pend_vec, outstanding, sb_err
  );

  modport slave (
    input  issue_valid, issue_reg_wr, issue_dest_idx, issue_lat_class,
    input  src_used, src_idx, flush, wb_valid, wb_dest_idx,
    output stall, fwd_sel, pend_vec, outstanding, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register scoreboard for the ID stage. It tracks every in-flight write
//   to the architectural register file. For each source operand it returns
//   either a stall or a bypass select. Each register owns a small state
//   machine: IDLE -> WAIT -> FWD1 -> FWD2 -> IDLE.
//     WAIT : the result is not yet on any bypass path.
//     FWD1 : the result is on the EX bypass.
//     FWD2 : the result is on the MEM bypass and stays there until WB retires it.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous, active-low reset
//     sb  : slave side of hazard_scoreboard_if
//           issue/retire inputs; stall, fwd_sel, pend_vec, outstanding, sb_err outputs
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 2,
  parameter int LD_LAT   = 2,
  parameter int MUL_LAT  = 3,
  parameter bit FWD_EN   = 1'b1
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);
  localparam int LAT_MAX = (LD_LAT > MUL_LAT) ? LD_LAT : MUL_LAT;
  // cnt holds at most LAT_MAX-1.
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX);
  localparam int OUT_W   = $clog2(NUM_REGS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FWD1, S_FWD2} ent_state_e;

  ent_state_e           state_q [NUM_REGS];
  ent_state_e           state_d [NUM_REGS];
  logic [CNT_W-1:0]     cnt_q   [NUM_REGS];
  logic [CNT_W-1:0]     cnt_d   [NUM_REGS];
  logic                 err_q, err_d;
  logic                 src_hazard, waw_hazard, stall_c;
  logic                 accept, retire;
  logic                 alloc_fwd1;
  logic [CNT_W-1:0]     alloc_cnt;
  logic [2*NUM_SRC-1:0] fwd_c;
  logic [NUM_REGS-1:0]  pend_c;
  logic [OUT_W-1:0]     outst_c;

  // Producer latency.
  // Class 3 is reserved and behaves like MUL.
  always_comb begin
    int lat;
    lat = MUL_LAT;
    case (sb.issue_lat_class)
      2'd0:    lat = 1;
      2'd1:    lat = LD_LAT;
      default: lat = MUL_LAT;
    endcase
    alloc_fwd1 = (lat == 1);
    alloc_cnt  = CNT_W'(lat - 1);
  end

  // Operand hazards and bypass selects. x0 and unused operands never hazard.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx        = '0;
    src_hazard = 1'b0;
    fwd_c      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = sb.src_idx[i*IDX_W +: IDX_W];
      if (sb.src_used[i] && (idx != '0)) begin
        case (state_q[idx])
          S_WAIT: src_hazard = 1'b1;
          S_FWD1: if (FWD_EN) fwd_c[2*i +: 2] = 2'd1; else src_hazard = 1'b1;
          S_FWD2: if (FWD_EN) fwd_c[2*i +: 2] = 2'd2; else src_hazard = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // One tracked write per register.
  // A second writer waits until the first has retired.
  assign waw_hazard = sb.issue_reg_wr && (state_q[sb.issue_dest_idx] != S_IDLE);
  assign stall_c    = sb.issue_valid && !sb.flush && (src_hazard || waw_hazard);
  assign accept     = sb.issue_valid && !stall_c && !sb.flush && sb.issue_reg_wr &&
                      (sb.issue_dest_idx != '0);
  assign retire     = sb.wb_valid && (sb.wb_dest_idx != '0);

  // Next state for each entry.
  // Retire overrides the natural progression.
  // Accept only ever targets an IDLE entry, because WAW stalls otherwise.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      state_d[r] = state_q[r];
      cnt_d[r]   = cnt_q[r];
      case (state_q[r])
        S_WAIT: begin
          if (cnt_q[r] == CNT_W'(1)) state_d[r] = S_FWD1;
          else                       cnt_d[r]   = cnt_q[r] - CNT_W'(1);
        end
        S_FWD1:  state_d[r] = S_FWD2;
        default: ;
      endcase
      if (retire && (sb.wb_dest_idx == IDX_W'(r)) && (state_q[r] != S_IDLE))
        state_d[r] = S_IDLE;
      if (accept && (sb.issue_dest_idx == IDX_W'(r))) begin
        state_d[r] = alloc_fwd1 ? S_FWD1 : S_WAIT;
        cnt_d[r]   = alloc_cnt;
      end
    end
  end

  // A retire to a register with no tracked write means the pipeline lost track of a write.
  assign err_d = err_q || (retire && (state_q[sb.wb_dest_idx] == S_IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        state_q[r] <= S_IDLE;
        cnt_q[r]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        state_q[r] <= state_d[r];
        cnt_q[r]   <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    pend_c  = '0;
    outst_c = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_c[r] = (state_q[r] != S_IDLE);
      outst_c   = outst_c + OUT_W'(pend_c[r]);
    end
  end

  assign sb.stall       = stall_c;
  assign sb.fwd_sel     = fwd_c;
  assign sb.pend_vec    = pend_c;
  assign sb.outstanding = outst_c;
  assign sb.sb_err      = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard. One instance has forwarding enabled
//   (dut_f). A second instance has forwarding disabled (dut_n). Both use
//   LD_LAT=2 and MUL_LAT=3. Each step drives inputs 1ns after a rising edge.
//   Outputs are checked 2ns later, well before the next edge.
module tb_hazard_scoreboard;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.NUM_REGS(32), .NUM_SRC(2)) bf ();
  hazard_scoreboard_if #(.NUM_REGS(32), .NUM_SRC(2)) bn ();

  hazard_scoreboard #(.NUM_REGS(32), .NUM_SRC(2), .LD_LAT(2), .MUL_LAT(3), .FWD_EN(1'b1))
    dut_f (.clk(clk), .rst(rst), .sb(bf.slave));
  hazard_scoreboard #(.NUM_REGS(32), .NUM_SRC(2), .LD_LAT(2), .MUL_LAT(3), .FWD_EN(1'b0))
    dut_n (.clk(clk), .rst(rst), .sb(bn.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n selects the instance: 0 = dut_f, 1 = dut_n.
  task automatic set_in(input bit n, input logic v, input logic wr, input int dest,
                        input int cls, input logic [1:0] used, input int s0, input int s1,
                        input logic fl, input logic wbv, input int wbd);
    if (!n) begin
      bf.issue_valid = v; bf.issue_reg_wr = wr; bf.issue_dest_idx = 5'(dest);
      bf.issue_lat_class = 2'(cls); bf.src_used = used; bf.src_idx = {5'(s1), 5'(s0)};
      bf.flush = fl; bf.wb_valid = wbv; bf.wb_dest_idx = 5'(wbd);
    end else begin
      bn.issue_valid = v; bn.issue_reg_wr = wr; bn.issue_dest_idx = 5'(dest);
      bn.issue_lat_class = 2'(cls); bn.src_used = used; bn.src_idx = {5'(s1), 5'(s0)};
      bn.flush = fl; bn.wb_valid = wbv; bn.wb_dest_idx = 5'(wbd);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    #3;
    chk("rst_pend_f",  bf.pend_vec, 0);
    chk("rst_outst_f", bf.outstanding, 0);
    chk("rst_err_f",   bf.sb_err, 0);
    chk("rst_stall_f", bf.stall, 0);
    chk("rst_fwd_f",   bf.fwd_sel, 0);
    chk("rst_pend_n",  bn.pend_vec, 0);
    rst = 1'b1;
    step();

    // ALU writer of x5, followed by readers on the EX and then the MEM bypass
    set_in(0, 1, 1, 5, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("alu_issue_stall", bf.stall, 0);
    step(); set_in(0, 1, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0); #2;
    chk("alu_t1_stall", bf.stall, 0);
    chk("alu_t1_fwd",   bf.fwd_sel, 4'b0001);
    chk("alu_t1_pend",  bf.pend_vec, 32'h20);
    chk("alu_t1_outst", bf.outstanding, 1);
    step(); set_in(0, 1, 0, 0, 0, 2'b10, 0, 5, 0, 0, 0); #2;
    chk("alu_t2_stall", bf.stall, 0);
    chk("alu_t2_fwd",   bf.fwd_sel, 4'b1000);
    step(); set_in(0, 0, 0, 0, 0, 2'b10, 0, 5, 0, 1, 5); #2;
    chk("alu_retire_fwd", bf.fwd_sel, 4'b1000);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("alu_done_pend",  bf.pend_vec, 0);
    chk("alu_done_outst", bf.outstanding, 0);

    // LOAD to x7: a reader stalls one cycle, then takes the EX bypass
    set_in(0, 1, 1, 7, 1, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("ld_issue_stall", bf.stall, 0);
    step(); set_in(0, 1, 0, 0, 0, 2'b01, 7, 0, 0, 0, 0); #2;
    chk("ld_t1_stall", bf.stall, 1);
    chk("ld_t1_fwd",   bf.fwd_sel, 0);
    step(); #2;
    chk("ld_t2_stall", bf.stall, 0);
    chk("ld_t2_fwd",   bf.fwd_sel, 4'b0001);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 7);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("ld_done_pend", bf.pend_vec, 0);

    // MUL to x9 with no forwarding: the reader stalls until after the retire
    set_in(1, 1, 1, 9, 2, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("mul_issue_stall", bn.stall, 0);
    for (int k = 1; k <= 4; k++) begin
      step(); set_in(1, 1, 0, 0, 0, 2'b10, 0, 9, 0, 0, 0); #2;
      chk($sformatf("mul_t%0d_stall", k), bn.stall, 1);
    end
    step(); set_in(1, 1, 0, 0, 0, 2'b10, 0, 9, 0, 1, 9); #2;
    chk("mul_retire_stall", bn.stall, 1);
    chk("mul_retire_fwd",   bn.fwd_sel, 0);
    step(); set_in(1, 1, 0, 0, 0, 2'b10, 0, 9, 0, 0, 0); #2;
    chk("mul_after_stall", bn.stall, 0);
    chk("mul_after_fwd",   bn.fwd_sel, 0);
    chk("mul_after_pend",  bn.pend_vec, 0);
    step(); set_in(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    step(); set_in(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("wb_x0_no_err", bn.sb_err, 0);

    // WAW on x3
    set_in(0, 1, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("waw_first_stall", bf.stall, 0);
    step(); #2;
    chk("waw_t1_stall", bf.stall, 1);
    chk("waw_t1_pend",  bf.pend_vec, 32'h8);
    chk("waw_t1_outst", bf.outstanding, 1);
    step(); #2;
    chk("waw_t2_stall", bf.stall, 1);
    step(); set_in(0, 1, 1, 3, 0, 2'b00, 0, 0, 0, 1, 3); #2;
    chk("waw_retire_stall", bf.stall, 1);
    step(); set_in(0, 1, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("waw_free_stall", bf.stall, 0);
    chk("waw_free_pend",  bf.pend_vec, 0);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 3); #2;
    chk("waw_realloc_pend",  bf.pend_vec, 32'h8);
    chk("waw_realloc_outst", bf.outstanding, 1);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("waw_done_pend", bf.pend_vec, 0);

    // x0 operand, unused operand and flush while x6 is pending
    set_in(0, 1, 1, 6, 0, 2'b00, 0, 0, 0, 0, 0);
    step(); set_in(0, 1, 1, 0, 0, 2'b01, 0, 6, 0, 0, 0); #2;
    chk("x0_unused_stall", bf.stall, 0);
    chk("x0_unused_fwd",   bf.fwd_sel, 0);
    step(); set_in(0, 1, 1, 6, 0, 2'b01, 6, 0, 1, 0, 0); #2;
    chk("x0_no_alloc_pend", bf.pend_vec, 32'h40);
    chk("x0_no_alloc_outst", bf.outstanding, 1);
    chk("flush_waw_stall", bf.stall, 0);
    step(); set_in(0, 1, 1, 10, 0, 2'b00, 0, 0, 1, 0, 0); #2;
    chk("flush_new_stall", bf.stall, 0);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 6); #2;
    chk("flush_no_alloc_pend", bf.pend_vec, 32'h40);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("flush_done_pend", bf.pend_vec, 0);

    // Three writes in flight, then an asynchronous reset, then a retire to an IDLE register
    set_in(0, 1, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    step(); set_in(0, 1, 1, 2, 2, 2'b00, 0, 0, 0, 0, 0);
    step(); set_in(0, 1, 1, 8, 2, 2'b00, 0, 0, 0, 0, 0);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("three_outst", bf.outstanding, 3);
    chk("three_pend",  bf.pend_vec, 32'h106);
    chk("three_err",   bf.sb_err, 0);
    rst = 1'b0; #1;
    chk("midrst_pend",  bf.pend_vec, 0);
    chk("midrst_outst", bf.outstanding, 0);
    rst = 1'b1;
    set_in(0, 1, 0, 0, 0, 2'b01, 2, 0, 0, 0, 0); #1;
    chk("midrst_reader_stall", bf.stall, 0);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4); #2;
    chk("err_before", bf.sb_err, 0);
    step(); set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0); #2;
    chk("err_set", bf.sb_err, 1);
    step(); #2;
    chk("err_sticky", bf.sb_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
